// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display driver: FSM encoding,
// saturation limit and active-low segment patterns ({g,f,e,d,c,b,a}).
package display_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      UPDATE  = 2'd2
   } state_e;

   localparam logic [15:0] SAT_MAX = 16'd9999;

   localparam logic [6:0] SEG_0   = 7'b1000000;
   localparam logic [6:0] SEG_1   = 7'b1111001;
   localparam logic [6:0] SEG_2   = 7'b0100100;
   localparam logic [6:0] SEG_3   = 7'b0110000;
   localparam logic [6:0] SEG_4   = 7'b0011001;
   localparam logic [6:0] SEG_5   = 7'b0010010;
   localparam logic [6:0] SEG_6   = 7'b0000010;
   localparam logic [6:0] SEG_7   = 7'b1111000;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0010000;
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      case (digit)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_OFF;
      endcase
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 16-bit binary to four BCD digits,
// one bit per cycle MSB first; the first shift happens on the start edge.
module bin2bcd_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [15:0] bin_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [15:0] bcd_o
);

   logic [15:0] bin_q, bin_d;
   logic [15:0] bcd_q, bcd_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // Add 3 to every BCD digit >= 5, then shift the whole {bcd, bin} left.
   function automatic logic [31:0] dd_step(input logic [31:0] acc);
      logic [31:0] adj;
      adj = acc;
      for (int i = 0; i < 4; i++) begin
         adj[16 + 4*i +: 4] = (adj[16 + 4*i +: 4] >= 4'd5) ?
                              adj[16 + 4*i +: 4] + 4'd3 : adj[16 + 4*i +: 4];
      end
      return {adj[30:0], 1'b0};
   endfunction

   // Next-state logic: load-and-shift on start, then 15 further shifts.
   always_comb begin
      bin_d  = bin_q;
      bcd_d  = bcd_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (busy_q) begin
         {bcd_d, bin_d} = dd_step({bcd_q, bin_q});
         cnt_d = cnt_q + 4'd1;
         if (cnt_q == 4'd15) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end else begin
            busy_d = 1'b1;
         end
      end else if (start_i) begin
         {bcd_d, bin_d} = dd_step({16'd0, bin_i});
         cnt_d  = 4'd1;
         busy_d = 1'b1;
      end else begin
         busy_d = 1'b0;
      end
   end

   // Converter state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q  <= 16'd0;
         bcd_q  <= 16'd0;
         cnt_q  <= 4'd0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign bcd_o  = bcd_q;

endmodule

// File: rtl/seven_seg_display_driver.sv
// Four-digit multiplexed seven-segment driver fed by a binary count.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_seg_display_driver
   import display_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value_in,
   input  logic        value_valid,
   output logic        busy,
   output logic        overflow,
   output logic [3:0]  an_n,
   output logic [6:0]  seg_n,
   output logic        dp_n
);

   localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] REFRESH_MAX = CW'(REFRESH_DIV - 1);

   state_e        state_q;
   logic          busy_q, overflow_q;
   logic [15:0]   digits_q;
   logic [CW-1:0] refresh_q, refresh_d;
   logic [1:0]    scan_q, scan_d;
   logic [3:0]    an_n_q;
   logic [6:0]    seg_n_q, seg_next_s;
   logic [3:0]    blank_s;
   logic [15:0]   sat_s, bcd_s;
   logic          start_s, conv_busy_s, conv_done_s;

   assign sat_s   = (value_in > SAT_MAX) ? SAT_MAX : value_in;
   assign start_s = (state_q == IDLE) && value_valid && !conv_busy_s;

   bin2bcd_seq u_bin2bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start_s),
      .bin_i   (sat_s),
      .busy_o  (conv_busy_s),
      .done_o  (conv_done_s),
      .bcd_o   (bcd_s)
   );

   // Control FSM; strobes outside IDLE are simply dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
         digits_q   <= 16'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_s) begin
                  state_q    <= CONVERT;
                  busy_q     <= 1'b1;
                  overflow_q <= (value_in > SAT_MAX);
               end
            end
            CONVERT: begin
               if (conv_done_s) state_q <= UPDATE;
            end
            UPDATE: begin
               digits_q <= bcd_s;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // A digit is blank when it and every more significant digit are zero.
   always_comb begin
      blank_s    = 4'b0000;
      blank_s[3] = (digits_q[15:12] == 4'd0);
      blank_s[2] = blank_s[3] && (digits_q[11:8] == 4'd0);
      blank_s[1] = blank_s[2] && (digits_q[7:4] == 4'd0);
   end
`else
   assign blank_s = 4'b0000;
`endif

   // Free-running refresh divider; display updates never disturb it.
   always_comb begin
      if (refresh_q == REFRESH_MAX) begin
         refresh_d = {CW{1'b0}};
         scan_d    = scan_q + 2'd1;
      end else begin
         refresh_d = refresh_q + CW'(1);
         scan_d    = scan_q;
      end
   end

   assign seg_next_s = blank_s[scan_q] ? SEG_OFF : seg_decode(digits_q[{scan_q, 2'b00} +: 4]);

   // Scan state plus registered anode/segment outputs, all on one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         refresh_q <= {CW{1'b0}};
         scan_q    <= 2'd0;
         an_n_q    <= 4'b1110;
         seg_n_q   <= SEG_0;
      end else begin
         refresh_q <= refresh_d;
         scan_q    <= scan_d;
         an_n_q    <= ~(4'b0001 << scan_q);
         seg_n_q   <= seg_next_s;
      end
   end

   assign busy     = busy_q;
   assign overflow = overflow_q;
   assign an_n     = an_n_q;
   assign seg_n    = seg_n_q;
   assign dp_n     = 1'b1;

endmodule

// File: tb/tb_seven_seg_display_driver.sv
// Self-checking bench for seven_seg_display_driver (REFRESH_DIV = 4):
// table-driven conversions with a scoreboard, plus drop and reset sequences.
module tb_seven_seg_display_driver;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] value_in = 16'd0;
   logic        value_valid = 1'b0;
   logic        busy, overflow, dp_n;
   logic [3:0]  an_n;
   logic [6:0]  seg_n;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int value;
      int exp_disp;
      bit exp_ovf;
   } vec_t;

   vec_t vecs[8];
   vec_t sb[$];

   seven_seg_display_driver #(.REFRESH_DIV(DIV)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .value_in    (value_in),
      .value_valid (value_valid),
      .busy        (busy),
      .overflow    (overflow),
      .an_n        (an_n),
      .seg_n       (seg_n),
      .dp_n        (dp_n)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input int v, input int d, input bit o);
      vec_t r;
      r.value = v;
      r.exp_disp = d;
      r.exp_ovf = o;
      return r;
   endfunction

   function automatic logic [6:0] exp_seg(input int disp, input int slot);
      int p10;
      int d;
      p10 = 1;
      for (int k = 0; k < slot; k++) p10 = p10 * 10;
      d = (disp / p10) % 10;
`ifdef LEADING_ZERO_BLANK_EN
      if (slot > 0 && disp < p10) return 7'b1111111;
`endif
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         default: return 7'b0010000;
      endcase
   endfunction

   function automatic logic [3:0] an_of(input int slot);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << slot);
   endfunction

   function automatic int slot_of(input logic [3:0] an);
      for (int i = 0; i < 4; i++) if (an === an_of(i)) return i;
      return 4;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Current anode must be one-hot; returns its slot (0 on a bad anode).
   task automatic cur_slot(input string name, output int slot);
      slot = slot_of(an_n);
      checks++;
      if (slot > 3) begin
         errors++;
         $display("FAIL %s: an_n %b not one-hot", name, an_n);
         slot = 0;
      end
   endtask

   // Follow a full 16-cycle scan: anode advances every DIV cycles.
   task automatic check_scan(input int disp);
      logic [3:0] prev;
      int n;
      int slot;
      int s;
      prev = an_n;
      n = 0;
      while (an_n === prev && n < 3*DIV) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (an_n === prev) begin
         errors++;
         $display("FAIL scan_advance: an_n stuck at %b", an_n);
         return;
      end
      cur_slot("scan_onehot", slot);
      for (int t = 0; t < 16; t++) begin
         s = (slot + t / DIV) % 4;
         chk("scan_an_n", an_n, an_of(s));
         chk("scan_seg_n", seg_n, exp_seg(disp, s));
         @(negedge clk);
      end
   endtask

   // Drive one strobe, then count busy cycles after the capture edge.
   task automatic convert(input int value, output int busy_cycles);
      @(negedge clk);
      value_in = value[15:0];
      value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      busy_cycles = 0;
      while (busy === 1'b1 && busy_cycles < 40) begin
         busy_cycles++;
         @(negedge clk);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t cur;
      int nb;
      int slot;
      int prev_disp;

      vecs[0] = mk(1234,  1234, 1'b0);
      vecs[1] = mk(65535, 9999, 1'b1);
      vecs[2] = mk(42,    42,   1'b0);
      vecs[3] = mk(0,     0,    1'b0);
      vecs[4] = mk(10000, 9999, 1'b1);
      vecs[5] = mk(9999,  9999, 1'b0);
      vecs[6] = mk(1000,  1000, 1'b0);
      vecs[7] = mk(7,     7,    1'b0);

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_an_n", an_n, 4'b1110);
      chk("rst_seg_n", seg_n, 7'b1000000);
      chk("rst_dp_n", dp_n, 1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      prev_disp = 0;
      for (int i = 0; i < 8; i++) begin
         sb.push_back(vecs[i]);
         convert(vecs[i].value, nb);
         chk("busy_cycles", nb, 17);
         cur = sb.pop_front();
         cur_slot("hold_onehot", slot);
         chk("seg_hold_17", seg_n, exp_seg(prev_disp, slot));
         @(negedge clk);
         cur_slot("new_onehot", slot);
         chk("seg_new_18", seg_n, exp_seg(cur.exp_disp, slot));
         chk("overflow", overflow, cur.exp_ovf);
         check_scan(cur.exp_disp);
         prev_disp = cur.exp_disp;
      end

      // Second strobe three cycles after capture must be dropped.
      sb.push_back(mk(500, 500, 1'b0));
      @(negedge clk);
      value_in = 16'd500;
      value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      repeat (2) @(negedge clk);
      value_in = 16'd777;
      value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      nb = 0;
      while (busy === 1'b1 && nb < 40) begin
         nb++;
         @(negedge clk);
      end
      chk("drop_busy_len", nb, 14);
      repeat (3) @(negedge clk);
      chk("drop_no_restart", busy, 0);
      cur = sb.pop_front();
      chk("drop_overflow", overflow, cur.exp_ovf);
      check_scan(cur.exp_disp);

      // Saturating value, then reset five cycles into the next conversion.
      convert(20000, nb);
      chk("sat_busy_cycles", nb, 17);
      chk("sat_overflow", overflow, 1);
      repeat (2) @(negedge clk);
      @(negedge clk);
      value_in = 16'd8888;
      value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cur_slot("conv_onehot", slot);
         chk("conv_hold_seg", seg_n, exp_seg(9999, slot));
         @(negedge clk);
      end
      #1 rst_n = 1'b0;
      #1;
      chk("async_busy", busy, 0);
      chk("async_overflow", overflow, 0);
      chk("async_an_n", an_n, 4'b1110);
      chk("async_seg_n", seg_n, 7'b1000000);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_overflow", overflow, 0);
      check_scan(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seven_seg_display_driver.md
SEVEN_SEG_DISPLAY_DRIVER -- requirements
Module: seven_seg_display_driver

Interface
REQ-001 SHALL provide parameter REFRESH_DIV, default 50000, clk cycles each digit is driven per scan slot (minimum 2).
REQ-002 SHALL provide port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port value_in  input  16  unsigned binary count from the frequency-counting stage.
REQ-005 SHALL provide port value_valid  input  1  one-cycle strobe qualifying value_in.
REQ-006 SHALL provide port busy  output  1  high while a conversion is in progress; new strobes are ignored.
REQ-007 SHALL provide port overflow  output  1  high when the last accepted value_in exceeded 9999.
REQ-008 SHALL provide port an_n  output  4  active-low one-hot digit enable; an_n[0] is the ones digit.
REQ-009 SHALL provide port seg_n  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-010 SHALL provide port dp_n  output  1  decimal point, tied high (off).

Function
REQ-011 SHALL implement FSM states IDLE, CONVERT, UPDATE; IDLE->CONVERT on value_valid, CONVERT->UPDATE after 16 shift cycles, UPDATE->IDLE after one cycle.
REQ-012 SHALL capture value_in at the edge where value_valid is sampled high in IDLE, saturating captured values above 9999 to 9999.
REQ-013 SHALL set overflow at the capture edge to (value_in > 9999) and hold it until the next capture.
REQ-014 SHALL convert using sequential shift-add-3 (double dabble), one bit per cycle, MSB first, 16-bit binary into four 4-bit BCD digits.
REQ-015 SHALL assert busy the cycle after capture through the UPDATE cycle (17 cycles).
REQ-016 SHALL load the displayed-digit register on the UPDATE edge; new digits appear on seg_n 18 cycles after the capture edge.
REQ-017 SHALL ignore value_valid while busy is high (strobe dropped, no queuing).
REQ-018 SHALL keep displaying the previous digits, unchanged, throughout CONVERT.
REQ-019 SHALL run a refresh counter 0..REFRESH_DIV-1 that wraps; on wrap the scan index advances 0->1->2->3->0.
REQ-020 SHALL NOT reset or stall the refresh counter or scan index when the displayed-digit register is updated.
REQ-021 SHALL decode digits 0-9 to standard patterns (0 = 1000000, 1 = 1111001, 8 = 0000000); unreachable codes 10-15 decode to all-off 1111111.
REQ-022 SHALL register an_n and seg_n so they change on the same edge, with no combinational glitch.

Reset
REQ-023 SHALL, while rst_n is low, force: state IDLE, busy 0, overflow 0, displayed digits 0000, refresh counter 0, scan index 0, an_n 1110, seg_n 1000000.
REQ-024 SHALL discard any conversion in progress when reset asserts mid-operation; the display returns to 0000.

Configuration
REQ-025 SHALL, with macro LEADING_ZERO_BLANK_EN defined, drive seg_n 1111111 for any zero digit more significant than the highest non-zero digit; the ones digit is never blanked.
REQ-026 SHALL, without LEADING_ZERO_BLANK_EN, display all four digits including leading zeros.

Structure
REQ-027 SHALL place the segment-pattern constants, the FSM state encoding and the 9999 saturation constant in shared package display_pkg.
REQ-028 SHALL implement the conversion in sub-module bin2bcd_seq, with start/busy/done handshake and a 16-bit input to 16-bit BCD output.

Verification
REQ-029 SHALL cover: reset, then value_valid with 1234 -> busy for 17 cycles; digits 4,3,2,1 scan on an_n 1110,1101,1011,0111; overflow 0.
REQ-030 SHALL cover: value_in 65535 -> display 9999, overflow 1; then 42 -> overflow 0, display 0042 (or blank-blank-4-2 with LEADING_ZERO_BLANK_EN).
REQ-031 SHALL cover: value_valid 500 then a second strobe with 777 three cycles later -> 777 ignored, display 0500.
REQ-032 SHALL cover: REFRESH_DIV=4, value 0 -> an_n advances every 4 cycles and wraps after 16; seg_n 1000000 in all slots without the macro.
REQ-033 SHALL cover: rst_n low 5 cycles into the conversion of 8888 -> outputs take reset values asynchronously; display stays 0000 after release.
